// File: rtl/read_buffer_ctrl.sv
// Read-path sequencer for the 3-line pixel buffer: fetches SDRAM words over Avalon-MM
// and steps the 3x3 filter window through the frame, 8 columns at a time.
module read_buffer_ctrl #(
  parameter int unsigned IMG_WIDTH    = 640,
  parameter int unsigned IMG_HEIGHT   = 480,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned PIX_PER_STEP = 6
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic        master_waitrequest,
  input  logic        master_readdatavalid,
  output logic        shift_enable24,
  output logic        load_read_buffer,
  output logic        shift_enable8,
  input  logic        pixel_done,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE, PRIME, PREFETCH, FILTER, SHIFT, NEXT_ROW
  } state_t;

  state_t      state;
  logic [15:0] row;
  logic [15:0] col;
  logic [1:0]  pf_row;
  logic [4:0]  issued_cnt;
  logic [4:0]  rx_cnt;
  logic [7:0]  pix_cnt;
  logic [2:0]  shift_cnt;

  logic       accept;
  logic       rx_evt;
  logic       can_issue;
  logic       more_cols;
  logic       more_cols_after_shift;
  logic       last_row;
  logic       pix_last;
  logic [4:0] issued_nxt;
  logic [4:0] rx_nxt;
  logic [4:0] target;

  function automatic logic [31:0] pix_addr(input logic [31:0] r, input logic [31:0] c);
    return BASE_ADDR + ((r * IMG_WIDTH + c) << 2);
  endfunction

  // Prime order is rows row+2, row+1, row so the oldest row ends up deepest in the cascade.
  function automatic logic [31:0] prime_addr(input logic [15:0] r, input logic [15:0] c,
                                             input logic [4:0] i);
    return pix_addr({16'd0, r} + 32'd2 - {30'd0, i[4:3]}, {16'd0, c} + {29'd0, i[2:0]});
  endfunction

  function automatic logic [31:0] prefetch_addr(input logic [15:0] r, input logic [1:0] p,
                                                input logic [15:0] c, input logic [2:0] i);
    return pix_addr({16'd0, r} + {30'd0, p}, {16'd0, c} + 32'd8 + {29'd0, i});
  endfunction

  assign accept     = master_read && !master_waitrequest;
  assign rx_evt     = master_readdatavalid && (state == PRIME || state == PREFETCH);
  assign issued_nxt = issued_cnt + {4'd0, accept};
  assign rx_nxt     = rx_cnt + {4'd0, rx_evt};
  assign target     = (state == PRIME) ? 5'd24 : 5'd8;
  assign can_issue  = (issued_nxt < target) && ((issued_nxt - rx_nxt) < 5'd8);

  assign more_cols             = ({16'd0, col} + 32'd8) < IMG_WIDTH;
  assign more_cols_after_shift = ({16'd0, col} + 32'd16) < IMG_WIDTH;
  assign last_row              = ({16'd0, row} + 32'd3) >= IMG_HEIGHT;
  assign pix_last              = ({24'd0, pix_cnt} + 32'd1) >= PIX_PER_STEP;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      row              <= '0;
      col              <= '0;
      pf_row           <= '0;
      issued_cnt       <= '0;
      rx_cnt           <= '0;
      pix_cnt          <= '0;
      shift_cnt        <= '0;
      master_address   <= '0;
      master_read      <= 1'b0;
      shift_enable24   <= 1'b0;
      load_read_buffer <= 1'b0;
      shift_enable8    <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= PRIME;
            busy           <= 1'b1;
            row            <= '0;
            col            <= '0;
            pf_row         <= '0;
            issued_cnt     <= '0;
            rx_cnt         <= '0;
            shift_enable24 <= 1'b1;
            master_read    <= 1'b1;
            master_address <= prime_addr(16'd0, 16'd0, 5'd0);
          end
        end

        PRIME, PREFETCH: begin
          issued_cnt <= issued_nxt;
          rx_cnt     <= rx_nxt;
          if (rx_nxt == target) begin
            issued_cnt  <= '0;
            rx_cnt      <= '0;
            master_read <= 1'b0;
            if (state == PRIME) begin
              shift_enable24 <= 1'b0;
              if (more_cols) begin
                state            <= PREFETCH;
                load_read_buffer <= 1'b1;
                master_read      <= 1'b1;
                master_address   <= prefetch_addr(row, pf_row, col, 3'd0);
              end else begin
                state <= FILTER;
              end
            end else begin
              load_read_buffer <= 1'b0;
              pf_row           <= (pf_row == 2'd2) ? 2'd0 : pf_row + 2'd1;
              state            <= FILTER;
            end
          end else if (!(master_read && master_waitrequest)) begin
            // A stalled request keeps its address; otherwise issue the next word if allowed.
            master_read <= can_issue;
            if (can_issue)
              master_address <= (state == PRIME) ? prime_addr(row, col, issued_nxt)
                                                 : prefetch_addr(row, pf_row, col, issued_nxt[2:0]);
          end
        end

        FILTER: begin
          if (pixel_done) begin
            if (pix_last) begin
              pix_cnt <= '0;
              if (more_cols) begin
                state         <= SHIFT;
                shift_enable8 <= 1'b1;
                shift_cnt     <= '0;
              end else begin
                state <= NEXT_ROW;
              end
            end else begin
              pix_cnt <= pix_cnt + 8'd1;
            end
          end
        end

        SHIFT: begin
          if (shift_cnt == 3'd7) begin
            shift_enable8 <= 1'b0;
            col           <= col + 16'd8;
            if (more_cols_after_shift) begin
              state            <= PREFETCH;
              load_read_buffer <= 1'b1;
              master_read      <= 1'b1;
              master_address   <= prefetch_addr(row, pf_row, col + 16'd8, 3'd0);
            end else begin
              state <= FILTER;
            end
          end else begin
            shift_cnt <= shift_cnt + 3'd1;
          end
        end

        NEXT_ROW: begin
          if (!last_row) begin
            state          <= PRIME;
            row            <= row + 16'd1;
            col            <= '0;
            pf_row         <= '0;
            issued_cnt     <= '0;
            rx_cnt         <= '0;
            shift_enable24 <= 1'b1;
            master_read    <= 1'b1;
            master_address <= prime_addr(row + 16'd1, 16'd0, 5'd0);
          end else begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_buffer_ctrl.sv
// Directed bench for read_buffer_ctrl on a 16x4 frame with a 2-cycle-latency Avalon slave model.
module tb_read_buffer_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [31:0] master_address;
  logic        master_read;
  logic        master_waitrequest = 1'b0;
  logic        master_readdatavalid = 1'b0;
  logic        shift_enable24;
  logic        load_read_buffer;
  logic        shift_enable8;
  logic        pixel_done;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  int acc_total = 0, valid_total = 0, v24 = 0, vload = 0, se8_cyc = 0, se8_out_err = 0;
  int excl_err = 0, fd_cnt = 0, prime_cnt = 0, hold_err = 0, stall_left = 0, stall_idx = 4;
  int lat = 6;
  int bad;
  logic [7:0]  pipe = '0;
  logic        stray_valid = 1'b0;
  logic        se24_q = 1'b0;
  logic        acc;
  logic [31:0] stall_addr = '0;
  logic [31:0] addr_log [0:127];
  logic [6:0]  seen;

  read_buffer_ctrl #(
    .IMG_WIDTH(16), .IMG_HEIGHT(4), .BASE_ADDR(BASE), .PIX_PER_STEP(6)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .master_address(master_address), .master_read(master_read),
    .master_waitrequest(master_waitrequest), .master_readdatavalid(master_readdatavalid),
    .shift_enable24(shift_enable24), .load_read_buffer(load_read_buffer),
    .shift_enable8(shift_enable8), .pixel_done(pixel_done),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Slave model plus monitors, all evaluated mid-cycle while DUT outputs are stable.
  always @(negedge clk) begin
    if (stall_left > 0 && stall_left < 3 && (!master_read || master_address !== stall_addr))
      hold_err++;
    if (master_read && acc_total == stall_idx && stall_left > 0) begin
      if (stall_left == 3) stall_addr = master_address;
      master_waitrequest = 1'b1;
      stall_left--;
    end else begin
      master_waitrequest = 1'b0;
    end
    acc = n_rst && master_read && !master_waitrequest;
    if (acc) begin
      if (acc_total < 128) addr_log[acc_total[6:0]] = master_address;
      acc_total++;
    end
    pipe = {pipe[6:0], acc};
    master_readdatavalid = pipe[lat] | stray_valid;
    if (master_readdatavalid) valid_total++;
    if (master_readdatavalid && shift_enable24) v24++;
    if (master_readdatavalid && load_read_buffer) vload++;
    if (shift_enable8) begin
      se8_cyc++;
      if (acc_total != valid_total) se8_out_err++;
    end
    if ((32'(shift_enable24) + 32'(load_read_buffer) + 32'(shift_enable8)) > 1) excl_err++;
    if (frame_done) fd_cnt++;
    if (shift_enable24 && !se24_q) prime_cnt++;
    se24_q = shift_enable24;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    start = s;
    pixel_done = p;
    tick();
    start = 1'b0;
    pixel_done = 1'b0;
  endtask

  task automatic pixel_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b1);
      tick();
    end
  endtask

  function automatic logic [31:0] exp_prime(input int r, input int i);
    return BASE + 32'(4 * ((r + 2 - i / 8) * 16 + i % 8));
  endfunction

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    pixel_done = 1'b0;
    repeat (3) tick();
    checkOutput("rst_read", master_read, 0);
    checkOutput("rst_addr", master_address, 0);
    checkOutput("rst_se24", shift_enable24, 0);
    checkOutput("rst_load", load_read_buffer, 0);
    checkOutput("rst_se8", shift_enable8, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    n_rst = 1'b1;
    tick();

    $display("[TB] reset during PRIME with slow slave");
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_latency_read", master_read, 1);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_se24", shift_enable24, 1);
    for (int i = 0; i < 30 && acc_total < 5; i++) tick();
    checkOutput("pre_reset_accepts", acc_total, 5);
    n_rst = 1'b0;
    tick();
    checkOutput("midrst_outputs",
                {master_read, shift_enable24, load_read_buffer, shift_enable8, busy, frame_done}, 0);
    checkOutput("midrst_addr", master_address, 0);
    n_rst = 1'b1;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      stray_valid = (i >= 2 && i < 5);
      tick();
      seen |= {master_read, shift_enable24, load_read_buffer, shift_enable8, busy, frame_done,
               |master_address};
    end
    stray_valid = 1'b0;
    checkOutput("stray_valid_idle", seen, 0);

    acc_total = 0; valid_total = 0; v24 = 0; vload = 0; se8_cyc = 0; se8_out_err = 0;
    excl_err = 0; fd_cnt = 0; prime_cnt = 0; hold_err = 0; pipe = '0;
    lat = 2; stall_idx = 4; stall_left = 3;
    tick();

    $display("[TB] row 0 with backpressure on read 5");
    applyStimulus(1'b1, 1'b0);
    checkOutput("frame_start_read", master_read, 1);
    for (int i = 0; i < 200 && shift_enable24; i++) tick();
    checkOutput("prime0_done", shift_enable24, 0);
    checkOutput("prime0_accepts", acc_total, 24);
    checkOutput("prime0_valids_se24", v24, 24);
    checkOutput("prime0_load_follows", load_read_buffer, 1);
    checkOutput("addr0", addr_log[0], BASE + 32'h80);
    checkOutput("addr1", addr_log[1], BASE + 32'h84);
    checkOutput("addr4_stalled", addr_log[4], BASE + 32'h90);
    checkOutput("addr8", addr_log[8], BASE + 32'h40);
    checkOutput("addr16", addr_log[16], BASE);
    checkOutput("addr23", addr_log[23], BASE + 32'h1C);
    bad = 0;
    for (int i = 0; i < 24; i++) if (addr_log[i] !== exp_prime(0, i)) bad++;
    checkOutput("prime0_addr_seq", bad, 0);
    checkOutput("stall_hold", hold_err, 0);
    checkOutput("stall_consumed", stall_left, 0);

    for (int i = 0; i < 100 && load_read_buffer; i++) tick();
    checkOutput("prefetch0_done", load_read_buffer, 0);
    checkOutput("prefetch0_accepts", acc_total, 32);
    checkOutput("prefetch0_valids", vload, 8);
    checkOutput("prefetch0_first_col", addr_log[24] & 32'h3F, 32'h20);
    checkOutput("prefetch0_last_col", addr_log[31] & 32'h3F, 32'h3C);

    pixel_pulses(5);
    checkOutput("five_pixels_no_shift", shift_enable8, 0);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("start_while_busy_se24", shift_enable24, 0);
    checkOutput("start_while_busy_reads", acc_total, 32);
    pixel_pulses(1);
    for (int i = 0; i < 20 && shift_enable8; i++) tick();
    checkOutput("shift0_done", shift_enable8, 0);
    checkOutput("shift0_cycles", se8_cyc, 8);
    checkOutput("shift0_no_outstanding", se8_out_err, 0);
    repeat (3) tick();
    checkOutput("end_of_row_no_prefetch", acc_total, 32);
    checkOutput("end_of_row_load_idle", load_read_buffer, 0);

    $display("[TB] row advance");
    pixel_pulses(6);
    for (int i = 0; i < 10 && !master_read; i++) tick();
    checkOutput("row1_read", master_read, 1);
    checkOutput("row1_first_addr", master_address, BASE + 32'hC0);
    checkOutput("row1_se24", shift_enable24, 1);
    for (int i = 0; i < 200 && shift_enable24; i++) tick();
    for (int i = 0; i < 100 && load_read_buffer; i++) tick();
    checkOutput("row1_fetch_done", load_read_buffer, 0);
    bad = 0;
    for (int i = 0; i < 24; i++) if (addr_log[32 + i] !== exp_prime(1, i)) bad++;
    checkOutput("prime1_addr_seq", bad, 0);
    pixel_pulses(6);
    for (int i = 0; i < 20 && shift_enable8; i++) tick();
    checkOutput("shift1_cycles", se8_cyc, 16);

    $display("[TB] frame end");
    pixel_pulses(6);
    for (int i = 0; i < 10 && !frame_done; i++) tick();
    checkOutput("frame_done_pulse", frame_done, 1);
    checkOutput("busy_falls_with_done", busy, 0);
    tick();
    checkOutput("frame_done_one_cycle", frame_done, 0);
    repeat (3) tick();
    checkOutput("frame_done_count", fd_cnt, 1);
    checkOutput("prime_count", prime_cnt, 2);
    checkOutput("total_reads", acc_total, 64);
    checkOutput("total_valids", valid_total, 64);
    checkOutput("enable_exclusive", excl_err, 0);
    checkOutput("shift_no_outstanding", se8_out_err, 0);
    checkOutput("idle_after_frame", {busy, master_read}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/read_buffer_ctrl.md
Name: read_buffer_ctrl

Overview:
- Sequencer for the 3-line pixel read buffer in the cartoonifier read path. Issues Avalon-MM master reads to SDRAM and drives load_read_buffer, shift_enable24 and shift_enable8 into the buffer. Paces the 3x3 filter window through the frame using pixel_done.
- Sits between the Avalon master port, the read buffer and the filter core. Owns frame and row/column bookkeeping.

Parameters:
- IMG_WIDTH, 640, pixels per row; must be a multiple of 8.
- IMG_HEIGHT, 480, rows per frame; must be at least 3.
- BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0); one 32-bit word per pixel, RGB in [23:0].
- PIX_PER_STEP, 6, pixel_done pulses consumed per 8-pixel window before the window shifts.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a frame when idle
- master_address  out  32  Avalon read byte address
- master_read  out  1  Avalon read request
- master_waitrequest  in  1  slave stall
- master_readdatavalid  in  1  read data valid; routed to the buffer in parallel
- shift_enable24  out  1  prime mode: each valid word enters line1 and cascades
- load_read_buffer  out  1  prefetch mode: each valid word enters the staging buffer
- shift_enable8  out  1  moves the staging buffer into line1, one word per cycle
- pixel_done  in  1  filter finished one output pixel
- busy  out  1  high from the accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last window

Behaviour:
- Reset: master_read, master_address, shift_enable24, load_read_buffer, shift_enable8, busy and frame_done are all 0. State is IDLE. Row counter is 0 and column counter is 0.
- Address: BASE_ADDR + 4*(row*IMG_WIDTH + col), computed in 32 bits with wrap (no saturation).
- Read issue rule:
  - master_read and master_address are held stable while master_waitrequest=1.
  - Each cycle with master_read=1 and master_waitrequest=0 counts as one accepted read; the address advances the next cycle.
  - issued_cnt counts accepted reads; rx_cnt counts master_readdatavalid pulses.
  - A phase ends only when rx_cnt reaches its target. Reads may be pipelined, at most 8 outstanding.
- States:
  - IDLE:
    - start=1 -> PRIME, busy=1, row=0, col=0.
    - start while busy is ignored.
  - PRIME:
    - shift_enable24=1 for the whole state.
    - Issues 24 reads: 8 words each from rows row+2, row+1, row, columns col..col+7, in that order, so the oldest data lands in line3.
    - Goes to PREFETCH when rx_cnt=24.
  - PREFETCH:
    - If col+8 < IMG_WIDTH: load_read_buffer=1; issue 8 reads for rows row..row+2 at columns col+8..col+15, one row per call. The 3-row interleave is handled by the shift order. Goes to FILTER when rx_cnt=8.
    - Otherwise goes straight to FILTER with no reads.
  - FILTER:
    - All enables are 0.
    - Counts pixel_done pulses; after PIX_PER_STEP pulses, go to SHIFT if more columns remain, else NEXT_ROW.
  - SHIFT:
    - shift_enable8=1 for exactly 8 consecutive cycles.
    - Then col += 8 and go to PREFETCH.
  - NEXT_ROW:
    - If row+3 < IMG_HEIGHT: row += 1, col = 0, go to PRIME.
    - Otherwise: frame_done=1 for one cycle, busy=0, go to IDLE.
- Enable exclusivity: shift_enable24, load_read_buffer and shift_enable8 are mutually exclusive. shift_enable8 is never asserted while reads are outstanding.
- Simultaneous events:
  - pixel_done outside FILTER is ignored.
  - master_readdatavalid outside PRIME/PREFETCH is ignored.
  - If pixel_done and the final rx word arrive in the same cycle, the word is counted and the pulse is dropped. Do not design around this: the filter only pulses in FILTER.
- Reset mid-operation: all counters clear and outputs return to reset values immediately. In-flight read data arriving after reset is ignored.
- Latency: start to first master_read = 1 cycle. Last valid word of PREFETCH to FILTER = 1 cycle.

Test Plan:
- Reset then idle: n_rst low mid-PRIME with 5 reads outstanding -> all outputs 0 next edge; later stray readdatavalid pulses do not move the FSM.
- Prime, zero wait: IMG_WIDTH=16, IMG_HEIGHT=3, waitrequest=0, 2-cycle read latency, start -> 24 reads; first addresses BASE+0x80, +0x84, ...; shift_enable24 high until the 24th valid word.
- Backpressure: waitrequest high for 3 cycles on read 5 -> master_address and master_read held; exactly 24 accepted reads, no duplicates or skips.
- Window step: after prefetch, 6 pixel_done pulses -> shift_enable8 high exactly 8 cycles; col=8; the next PREFETCH issues no reads (end of row).
- Frame end: 16x3 frame -> one row pass, then frame_done one-cycle pulse with busy falling in the same cycle. A start during busy is ignored.
- Row advance: 16x4 frame -> second PRIME begins at row 1 address BASE+4*16*3 (top row of fetch = row+2 = 3), and exactly 2 rows are processed before frame_done.
